// File: rtl/pipeline_pkg.sv
// Shared types and constants for the ID-stage hazard/stall logic of the 5-stage MIPS pipeline.
package pipeline_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_e;

    localparam logic [4:0]  REG_ZERO      = 5'd0;
    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // Control word injected into ID/EX when a bubble is inserted.
    localparam ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones; clear has priority over enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard detection: load-use and branch-operand stalls, IF/ID flush on taken
// branches/jumps, and saturating stall/flush cycle counters.
module hazard_stall_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_Branch,
    input  logic             IF_ID_Jump,
    input  logic             BranchTaken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_RegisterRd,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_RegisterRd,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCycles
);

    stall_state_e state_q;
    stall_state_e state_d;
    stall_state_e cur_state;

    logic m_ex;
    logic m_mem;
    logic load_use;
    logic br_alu;
    logic br_load_ex;
    logic br_load_mem;
    logic stall_now;
    logic flush_now;

    always_comb begin
        m_ex  = (ID_EX_RegisterRd != REG_ZERO) &&
                ((ID_EX_RegisterRd == IF_ID_RegisterRs) ||
                 (IF_ID_UsesRt && (ID_EX_RegisterRd == IF_ID_RegisterRt)));
        m_mem = (EX_MEM_RegisterRd != REG_ZERO) &&
                ((EX_MEM_RegisterRd == IF_ID_RegisterRs) ||
                 (IF_ID_UsesRt && (EX_MEM_RegisterRd == IF_ID_RegisterRt)));

        load_use    = ID_EX_MemRead && m_ex;
        br_alu      = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && m_ex;
        br_load_ex  = IF_ID_Branch && ID_EX_MemRead && m_ex;
        br_load_mem = IF_ID_Branch && EX_MEM_MemRead && m_mem;
    end

    // While reset is held the outputs follow the inputs as if already in RUN.
    always_comb begin
        cur_state = reset ? RUN : state_q;

        stall_now = (cur_state == STALL) || load_use || br_alu || br_load_ex || br_load_mem;
        flush_now = !stall_now && ((IF_ID_Branch && BranchTaken) || IF_ID_Jump);

        PCWrite      = !stall_now;
        IF_ID_Write  = !stall_now;
        ID_EX_Bubble = stall_now;
        IF_ID_Flush  = flush_now;
        Busy         = (cur_state == STALL);
    end

    always_comb begin
        state_d = state_q;
        if (reset) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:     state_d = br_load_ex ? STALL : RUN;
                STALL:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (stall_now),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (flush_now),
        .count (FlushCycles)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed-vector bench for hazard_stall_controller, built with CNT_W=4 to reach saturation quickly.
module tb_hazard_stall_controller;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic [4:0]    if_id_rs;
    logic [4:0]    if_id_rt;
    logic          if_id_uses_rt;
    logic          if_id_branch;
    logic          if_id_jump;
    logic          branch_taken;
    logic          id_ex_mem_read;
    logic          id_ex_reg_write;
    logic [4:0]    id_ex_rd;
    logic          ex_mem_mem_read;
    logic [4:0]    ex_mem_rd;
    logic          pc_write;
    logic          if_id_write;
    logic          id_ex_bubble;
    logic          if_id_flush;
    logic          busy;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_cycles;

    int unsigned n_checks;
    int unsigned n_pass;

    hazard_stall_controller #(.CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .IF_ID_RegisterRs  (if_id_rs),
        .IF_ID_RegisterRt  (if_id_rt),
        .IF_ID_UsesRt      (if_id_uses_rt),
        .IF_ID_Branch      (if_id_branch),
        .IF_ID_Jump        (if_id_jump),
        .BranchTaken       (branch_taken),
        .ID_EX_MemRead     (id_ex_mem_read),
        .ID_EX_RegWrite    (id_ex_reg_write),
        .ID_EX_RegisterRd  (id_ex_rd),
        .EX_MEM_MemRead    (ex_mem_mem_read),
        .EX_MEM_RegisterRd (ex_mem_rd),
        .PCWrite           (pc_write),
        .IF_ID_Write       (if_id_write),
        .ID_EX_Bubble      (id_ex_bubble),
        .IF_ID_Flush       (if_id_flush),
        .Busy              (busy),
        .StallCycles       (stall_cycles),
        .FlushCycles       (flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        if_id_rs        = 5'd0;
        if_id_rt        = 5'd0;
        if_id_uses_rt   = 1'b0;
        if_id_branch    = 1'b0;
        if_id_jump      = 1'b0;
        branch_taken    = 1'b0;
        id_ex_mem_read  = 1'b0;
        id_ex_reg_write = 1'b0;
        id_ex_rd        = 5'd0;
        ex_mem_mem_read = 1'b0;
        ex_mem_rd       = 5'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_stall(input string tag, input int exp_stall);
        check_eq({tag, ".pcw"},    int'(pc_write),     exp_stall ? 0 : 1);
        check_eq({tag, ".ifidw"},  int'(if_id_write),  exp_stall ? 0 : 1);
        check_eq({tag, ".bubble"}, int'(id_ex_bubble), exp_stall);
    endtask

    task automatic set_branch_on_load();
        clear_inputs();
        if_id_branch   = 1'b1;
        if_id_uses_rt  = 1'b1;
        if_id_rs       = 5'd3;
        if_id_rt       = 5'd9;
        branch_taken   = 1'b1;
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd9;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        clear_inputs();
        tick();
        tick();
        check_stall("rst", 0);
        check_eq("rst.busy",  int'(busy),         0);
        check_eq("rst.flush", int'(if_id_flush),  0);
        check_eq("rst.scnt",  int'(stall_cycles), 0);
        check_eq("rst.fcnt",  int'(flush_cycles), 0);
        reset = 1'b0;
        tick();

        // Load-use on rs
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd8;
        if_id_rs       = 5'd8;
        settle();
        check_stall("lu", 1);
        check_eq("lu.busy", int'(busy), 0);
        tick();
        clear_inputs();
        settle();
        check_eq("lu.scnt", int'(stall_cycles), 1);
        check_eq("lu.busy2", int'(busy), 0);
        check_stall("lu.after", 0);

        // Register $0 never a source
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd0;
        if_id_rs       = 5'd0;
        settle();
        check_stall("zero", 0);
        tick();
        check_eq("zero.scnt", int'(stall_cycles), 1);

        // rt match ignored when rt is not read
        clear_inputs();
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd12;
        if_id_rs       = 5'd1;
        if_id_rt       = 5'd12;
        settle();
        check_stall("nort", 0);
        if_id_uses_rt = 1'b1;
        settle();
        check_stall("rt", 1);
        tick();

        // Branch on ALU result in EX: one-cycle stall, no flush
        do_reset();
        if_id_branch    = 1'b1;
        branch_taken    = 1'b1;
        if_id_rs        = 5'd5;
        id_ex_reg_write = 1'b1;
        id_ex_rd        = 5'd5;
        settle();
        check_stall("bralu", 1);
        check_eq("bralu.flush", int'(if_id_flush), 0);
        tick();
        check_eq("bralu.busy", int'(busy), 0);

        // Branch on load in MEM
        clear_inputs();
        if_id_branch    = 1'b1;
        if_id_uses_rt   = 1'b1;
        if_id_rt        = 5'd7;
        ex_mem_mem_read = 1'b1;
        ex_mem_rd       = 5'd7;
        settle();
        check_stall("brmem", 1);
        ex_mem_mem_read = 1'b0;
        settle();
        check_stall("brmem.noload", 0);

        // Branch on load in EX: two stalls, then taken flush
        do_reset();
        set_branch_on_load();
        settle();
        check_stall("brld.c1", 1);
        check_eq("brld.c1.busy",  int'(busy),        0);
        check_eq("brld.c1.flush", int'(if_id_flush), 0);
        tick();
        id_ex_mem_read = 1'b0;
        id_ex_rd       = 5'd0;
        settle();
        check_stall("brld.c2", 1);
        check_eq("brld.c2.busy",  int'(busy),        1);
        check_eq("brld.c2.flush", int'(if_id_flush), 0);
        tick();
        check_eq("brld.scnt",     int'(stall_cycles), 2);
        check_eq("brld.c3.busy",  int'(busy),         0);
        check_stall("brld.c3", 0);
        check_eq("brld.c3.flush", int'(if_id_flush),  1);
        tick();
        clear_inputs();
        settle();
        check_eq("brld.c4.flush", int'(if_id_flush),  0);
        check_eq("brld.fcnt",     int'(flush_cycles), 1);
        tick();
        check_eq("brld.fcnt2",    int'(flush_cycles), 1);
        check_eq("brld.scnt2",    int'(stall_cycles), 2);

        // Jump flush, and untaken branch no flush
        if_id_jump = 1'b1;
        settle();
        check_eq("jmp.flush", int'(if_id_flush), 1);
        tick();
        check_eq("jmp.fcnt", int'(flush_cycles), 2);
        clear_inputs();
        if_id_branch = 1'b1;
        settle();
        check_eq("nt.flush", int'(if_id_flush), 0);

        // Reset asserted during STALL
        do_reset();
        set_branch_on_load();
        tick();
        clear_inputs();
        settle();
        check_eq("rms.busy.pre", int'(busy), 1);
        reset = 1'b1;
        settle();
        check_eq("rms.busy.inrst", int'(busy), 0);
        check_stall("rms.inrst", 0);
        tick();
        check_eq("rms.busy", int'(busy),         0);
        check_eq("rms.scnt", int'(stall_cycles), 0);
        check_eq("rms.fcnt", int'(flush_cycles), 0);
        reset = 1'b0;
        tick();
        check_eq("rms.busy.post", int'(busy), 0);

        // Saturation at 4'hF
        do_reset();
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd8;
        if_id_rs       = 5'd8;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) check_eq("sat.at15", int'(stall_cycles), 15);
        end
        check_eq("sat.hold", int'(stall_cycles), 15);
        check_stall("sat", 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Companion to the EX-stage forwarding logic; sits in the ID stage of the 5-stage MIPS pipeline.
- Handles the hazards forwarding cannot resolve:
  - load-use on ordinary instructions;
  - data dependences of ID-resolved branches on EX/MEM producers;
  - flushing IF/ID after a taken branch or jump.
- A small FSM sequences two-cycle stalls. Saturating counters record stall and flush cycles for performance reporting.

Parameters:
- CNT_W, 16, width of the StallCycles and FlushCycles counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  synchronous, active-high reset
- IF_ID_RegisterRs  input  5  rs of the instruction in ID
- IF_ID_RegisterRt  input  5  rt of the instruction in ID
- IF_ID_UsesRt  input  1  instruction in ID reads rt (R-type, beq/bne, sw)
- IF_ID_Branch  input  1  instruction in ID is beq/bne
- IF_ID_Jump  input  1  instruction in ID is j/jal/jr
- BranchTaken  input  1  ID-stage branch comparison result (meaningful only when IF_ID_Branch=1)
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_RegWrite  input  1  instruction in EX writes a register
- ID_EX_RegisterRd  input  5  destination of the instruction in EX (after RegDst mux)
- EX_MEM_MemRead  input  1  instruction in MEM is a load
- EX_MEM_RegisterRd  input  5  destination of the instruction in MEM
- PCWrite  output  1  0 = hold PC
- IF_ID_Write  output  1  0 = hold IF/ID register
- ID_EX_Bubble  output  1  1 = zero the control fields entering ID/EX
- IF_ID_Flush  output  1  1 = replace IF/ID contents with a NOP
- Busy  output  1  FSM is in the STALL state
- StallCycles  output  CNT_W  count of stall cycles
- FlushCycles  output  CNT_W  count of flush cycles

Behaviour:
- Interface: single clock clk. Reset is synchronous and active-high, on port reset.
- Match terms:
  - mEX = ID_EX_RegisterRd != 0 && (ID_EX_RegisterRd == IF_ID_RegisterRs || (IF_ID_UsesRt && ID_EX_RegisterRd == IF_ID_RegisterRt))
  - mMEM is defined the same way using EX_MEM_RegisterRd.
- Hazard terms:
  - load_use = ID_EX_MemRead && mEX
  - br_alu = IF_ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && mEX
  - br_load_ex = IF_ID_Branch && ID_EX_MemRead && mEX (needs 2 stalls)
  - br_load_mem = IF_ID_Branch && EX_MEM_MemRead && mMEM
- stall_now:
  - In RUN: load_use || br_alu || br_load_mem.
  - In STALL: 1 unconditionally.
- Stall outputs:
  - When stall_now=1: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - Otherwise: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - These are Mealy outputs with 0 cycles of latency from the inputs.
- FSM:
  - RUN -> STALL when br_load_ex (this cycle stalls too).
  - STALL -> RUN always after exactly one cycle. Input-driven hazards are re-evaluated in the following RUN cycle.
  - Busy = (state == STALL).
- Flush:
  - IF_ID_Flush = !stall_now && ((IF_ID_Branch && BranchTaken) || IF_ID_Jump).
  - Flush is suppressed during a stall because the branch operands are not yet valid.
  - Stall and flush are never asserted together.
- Counters:
  - StallCycles increments on each cycle with stall_now=1.
  - FlushCycles increments on each cycle with IF_ID_Flush=1.
  - Both saturate at all-ones and never wrap.
- Reset (also mid-stall):
  - state=RUN, both counters=0.
  - During reset the outputs are combinational from the inputs with state=RUN.
- Register $0 is never a hazard source.
- Simultaneous load_use and br_load_ex (a branch depending on a load in EX): the two-cycle path wins.

Decomposition:
- Shared package (pipeline_pkg): FSM state typedef {RUN, STALL}, REG_ZERO=5'd0, NOP control-word constant, CNT_W default.
- One sub-module: sat_counter (CNT_W width; en and clear inputs; saturating at all-ones), instantiated twice.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRd=8, IF_ID_RegisterRs=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1 for 1 cycle; StallCycles 0->1; Busy stays 0.
- Zero register: ID_EX_MemRead=1, ID_EX_RegisterRd=0, IF_ID_RegisterRs=0 -> no stall; PCWrite=1.
- Branch on load: IF_ID_Branch=1, IF_ID_UsesRt=1, IF_ID_RegisterRt=9, ID_EX_MemRead=1, ID_EX_RegisterRd=9 -> 2 consecutive stall cycles; Busy=1 in cycle 2; IF_ID_Flush=0 both cycles; StallCycles=2.
- Taken branch after stall: same as the previous case, then BranchTaken=1 in the following RUN cycle with no hazard -> IF_ID_Flush=1 for exactly 1 cycle; FlushCycles=1.
- Reset mid-stall: assert reset during the STALL cycle -> next cycle Busy=0, StallCycles=0, FlushCycles=0.
- Saturation: CNT_W=4, hold a load-use hazard for 20 cycles -> StallCycles holds at 15 (4'hF) and does not wrap.
